boot_run_ctrl: RTL

- Boot and run sequencer for the pipelined core (pipeline_top).
- After a start pulse, streams an image from a 64-bit source ROM into instruction memory (32-bit words) and data memory (64-bit doublewords), both byte-addressed.
- Holds the core in reset during load, then releases it and drives its enable.
- In run mode, counts core cycles, stops on a halt request or a watchdog limit, and reports status.

---
 rtl/boot_run_ctrl_if.sv | 51 +++++
 rtl/boot_run_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/boot_run_ctrl_if.sv
// Boot/run sequencer bundle: source ROM, instruction/data memory write ports, core control and status.
// With BOOT_CHECKSUM_EN defined it also carries the expected image checksum and the checksum error flag.
interface boot_run_ctrl_if #(
    parameter int SRC_AW  = 8,
    parameter int IMEM_AW = 10,
    parameter int DMEM_AW = 10
);
    logic               start;
    logic               src_rd;
    logic [SRC_AW-1:0]  src_addr;
    logic [63:0]        src_data;
    logic               imem_we;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_wdata;
    logic               dmem_we;
    logic [DMEM_AW-1:0] dmem_addr;
    logic [63:0]        dmem_wdata;
    logic               cpu_rst;
    logic               cpu_enable;
    logic               halt;
    logic               busy;
    logic               done;
    logic               timeout;
    logic [31:0]        cycle_count;
`ifdef BOOT_CHECKSUM_EN
    logic [63:0]        exp_checksum;
    logic               checksum_err;
`endif

    modport master (
`ifdef BOOT_CHECKSUM_EN
        input  exp_checksum,
        output checksum_err,
`endif
        input  start, src_data, halt,
        output src_rd, src_addr, imem_we, imem_addr, imem_wdata,
        output dmem_we, dmem_addr, dmem_wdata,
        output cpu_rst, cpu_enable, busy, done, timeout, cycle_count
    );

    modport slave (
`ifdef BOOT_CHECKSUM_EN
        output exp_checksum,
        input  checksum_err,
`endif
        output start, src_data, halt,
        input  src_rd, src_addr, imem_we, imem_addr, imem_wdata,
        input  dmem_we, dmem_addr, dmem_wdata,
        input  cpu_rst, cpu_enable, busy, done, timeout, cycle_count
    );
endinterface

// File: rtl/boot_run_ctrl.sv
// Boot and run sequencer: streams a ROM image into imem/dmem, releases the core, then watches it run.
// Optional image checksum check in SETTLE is enabled by defining BOOT_CHECKSUM_EN.
module boot_run_ctrl #(
    parameter int INST_WORDS  = 64,
    parameter int DATA_DWORDS = 32,
    parameter int SRC_AW      = 8,
    parameter int IMEM_AW     = 10,
    parameter int DMEM_AW     = 10,
    parameter int MAX_CYCLES  = 1000
) (
    input logic            clk_in,
    input logic            rst,
    boot_run_ctrl_if.master bus
);
    localparam int TOTAL = INST_WORDS + DATA_DWORDS;
    localparam int IW    = $clog2(TOTAL + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_SETTLE,
        S_RUN,
        S_HALTED
    } state_t;

    state_t             state_q;
    logic [IW-1:0]      rd_idx_q;
    logic               src_rd_q;
    logic               imem_we_q;
    logic               dmem_we_q;
    logic [IMEM_AW-1:0] imem_addr_q;
    logic [DMEM_AW-1:0] dmem_addr_q;
    logic               cpu_rst_q;
    logic               cpu_en_q;
    logic               busy_q;
    logic               done_q;
    logic               timeout_q;
    logic [31:0]        cycle_q;
    logic [31:0]        cycle_d;
    logic               csum_ok_d;

    assign cycle_d = cycle_q + 32'd1;

`ifdef BOOT_CHECKSUM_EN
    logic [63:0] csum_q;
    logic        csum_err_q;
    assign csum_ok_d        = (csum_q == bus.exp_checksum);
    assign bus.checksum_err = csum_err_q;
`else
    assign csum_ok_d = 1'b1;
`endif

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rd_idx_q    <= '0;
            src_rd_q    <= 1'b0;
            imem_we_q   <= 1'b0;
            dmem_we_q   <= 1'b0;
            imem_addr_q <= '0;
            dmem_addr_q <= '0;
            cpu_rst_q   <= 1'b1;
            cpu_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            cycle_q     <= '0;
`ifdef BOOT_CHECKSUM_EN
            csum_q      <= '0;
            csum_err_q  <= 1'b0;
`endif
        end else begin
            // Write stage: each read lands in memory one cycle later, when its data is valid.
            imem_we_q <= src_rd_q && (rd_idx_q < IW'(INST_WORDS));
            dmem_we_q <= src_rd_q && (rd_idx_q >= IW'(INST_WORDS));
            if (src_rd_q && (rd_idx_q < IW'(INST_WORDS)))
                imem_addr_q <= IMEM_AW'(rd_idx_q) << 2;
            if (src_rd_q && (rd_idx_q >= IW'(INST_WORDS)))
                dmem_addr_q <= DMEM_AW'(rd_idx_q - IW'(INST_WORDS)) << 3;
`ifdef BOOT_CHECKSUM_EN
            if (imem_we_q || dmem_we_q)
                csum_q <= csum_q ^ bus.src_data;
`endif

            case (state_q)
                S_IDLE, S_HALTED: begin
                    if (bus.start) begin
                        state_q   <= S_LOAD;
                        rd_idx_q  <= '0;
                        src_rd_q  <= 1'b1;
                        cpu_rst_q <= 1'b1;
                        cpu_en_q  <= 1'b0;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        timeout_q <= 1'b0;
                        cycle_q   <= '0;
`ifdef BOOT_CHECKSUM_EN
                        csum_q     <= '0;
                        csum_err_q <= 1'b0;
`endif
                    end
                end
                S_LOAD: begin
                    if (rd_idx_q == IW'(TOTAL - 1)) begin
                        state_q  <= S_DRAIN;
                        src_rd_q <= 1'b0;
                    end else begin
                        rd_idx_q <= rd_idx_q + IW'(1);
                    end
                end
                S_DRAIN: begin
                    state_q   <= S_SETTLE;
                    cpu_rst_q <= 1'b0;
                end
                S_SETTLE: begin
                    busy_q <= 1'b0;
                    if (csum_ok_d) begin
                        state_q  <= S_RUN;
                        cpu_en_q <= 1'b1;
                    end else begin
                        state_q <= S_HALTED;
                        done_q  <= 1'b1;
`ifdef BOOT_CHECKSUM_EN
                        csum_err_q <= 1'b1;
`endif
                    end
                end
                S_RUN: begin
                    // The halting cycle still counts; halt outranks a simultaneous watchdog expiry.
                    cycle_q <= cycle_d;
                    if (bus.halt) begin
                        state_q  <= S_HALTED;
                        cpu_en_q <= 1'b0;
                        done_q   <= 1'b1;
                    end else if (cycle_d == 32'(MAX_CYCLES)) begin
                        state_q   <= S_HALTED;
                        cpu_en_q  <= 1'b0;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.src_rd      = src_rd_q;
    assign bus.src_addr    = src_rd_q ? SRC_AW'(rd_idx_q) : '0;
    assign bus.imem_we     = imem_we_q;
    assign bus.imem_addr   = imem_addr_q;
    assign bus.imem_wdata  = imem_we_q ? bus.src_data[31:0] : 32'd0;
    assign bus.dmem_we     = dmem_we_q;
    assign bus.dmem_addr   = dmem_addr_q;
    assign bus.dmem_wdata  = dmem_we_q ? bus.src_data : 64'd0;
    assign bus.cpu_rst     = cpu_rst_q;
    assign bus.cpu_enable  = cpu_en_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.timeout     = timeout_q;
    assign bus.cycle_count = cycle_q;
endmodule
